// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game front-end blocks.
//   - deb_state_e : key debounce FSM states
//   - CLOCK_50MHZ : board clock frequency in Hz
//   - DEBOUNCE_DEFAULT / LONGPRESS_DEFAULT : default cycle counts
//   - cnt_width() : width of a saturating counter able to hold both limits
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int CLOCK_50MHZ       = 50_000_000;
    localparam int DEBOUNCE_DEFAULT  = CLOCK_50MHZ / 50;   // 20 ms
    localparam int LONGPRESS_DEFAULT = CLOCK_50MHZ * 2;    // 2 s

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_e;

    // One spare bit above the larger limit so a saturated counter can never
    // alias back onto a compare value.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// One raw active-low key: 2-flop synchronizer followed by a debounce FSM.
//   clock, reset : system clock, asynchronous active-high reset
//   key_n        : raw key, active low, asynchronous to clock
//   held         : 1 while the key is accepted as pressed
//   press_evt    : 1 for the cycle in which a press is accepted (combinational,
//                  coincides with the edge that raises held)
// ---------------------------------------------------------------------------
module key_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = cnt_width(DEBOUNCE_DEFAULT, LONGPRESS_DEFAULT)
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic held,
    output logic press_evt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync;
    logic             sample_n;
    deb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             cnt_max;

    // Synchronizer resets to "released" so a key held through reset is
    // re-qualified from scratch.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], key_n};
    end

    assign sample_n  = sync[1];
    assign cnt_done  = (cnt == CNT_LAST);
    assign cnt_max   = &cnt;
    assign press_evt = (state == PRESS_WAIT) && !sample_n && cnt_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RELEASED;
            cnt   <= '0;
            held  <= 1'b0;
        end else begin
            case (state)
                RELEASED: begin
                    if (!sample_n) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (sample_n) begin            // glitch rejected
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt_done) begin
                        state <= PRESSED;
                        held  <= 1'b1;
                        cnt   <= '0;
                    end else if (!cnt_max) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (sample_n) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!sample_n) begin           // release bounce, no new pulse
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt_done) begin
                        state <= RELEASED;
                        held  <= 1'b0;
                        cnt   <= '0;
                    end else if (!cnt_max) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
// Turns the raw start/pause keys into debounced, single-cycle active-low
// command pulses plus debounced key levels.
//   clock, reset    : system clock, asynchronous active-high reset
//   key_start_n     : raw KEY0, active low
//   key_pause_n     : raw KEY1, active low
//   start, pause    : active-low one-cycle press pulses, never low together
//   start_held      : debounced KEY0 level (1 = pressed)
//   pause_held      : debounced KEY1 level (1 = pressed)
//   long_reset_req  : active-high one-cycle long-press request
// Build option: define KEY_LONGPRESS_EN to build the long-press counter;
// otherwise long_reset_req is tied to 0.
// ---------------------------------------------------------------------------
module key_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEBOUNCE_DEFAULT,
    parameter int LONGPRESS_CYCLES = LONGPRESS_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic key_start_n,
    input  logic key_pause_n,
    output logic start,
    output logic pause,
    output logic start_held,
    output logic pause_held,
    output logic long_reset_req
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONGPRESS_CYCLES);

    logic start_evt, pause_evt;
    logic start_pend, pause_pend;
    logic start_pend_nxt, pause_pend_nxt;
    logic start_fire, pause_fire;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_start_deb (
        .clock     (clock),
        .reset     (reset),
        .key_n     (key_start_n),
        .held      (start_held),
        .press_evt (start_evt)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_pause_deb (
        .clock     (clock),
        .reset     (reset),
        .key_n     (key_pause_n),
        .held      (pause_held),
        .press_evt (pause_evt)
    );

    // Arbitration: a deferred pulse goes out first; otherwise pause wins a
    // same-cycle tie and start is parked for exactly one cycle. Presses of one
    // key are far apart, so a single pending flag per key cannot overflow.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        start_fire     = 1'b0;
        pause_fire     = 1'b0;
        start_pend_nxt = 1'b0;
        pause_pend_nxt = 1'b0;
        if (start_pend) begin
            start_fire     = 1'b1;
            pause_pend_nxt = pause_evt;
        end else if (pause_pend || pause_evt) begin
            pause_fire     = 1'b1;
            start_pend_nxt = start_evt;
        end else if (start_evt) begin
            start_fire = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start      <= 1'b1;
            pause      <= 1'b1;
            start_pend <= 1'b0;
            pause_pend <= 1'b0;
        end else begin
            start      <= ~start_fire;
            pause      <= ~pause_fire;
            start_pend <= start_pend_nxt;
            pause_pend <= pause_pend_nxt;
        end
    end

`ifdef KEY_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(LONGPRESS_CYCLES);
    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(LONGPRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] lp_cnt;
    logic             both_held;

    assign both_held = start_held & pause_held;

    // Counter parks at the limit, so one request per continuous double hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lp_cnt         <= '0;
            long_reset_req <= 1'b0;
        end else if (!both_held) begin
            lp_cnt         <= '0;
            long_reset_req <= 1'b0;
        end else if (lp_cnt < LP_LIMIT) begin
            lp_cnt         <= lp_cnt + LP_ONE;
            long_reset_req <= (lp_cnt == LP_LAST);
        end else begin
            long_reset_req <= 1'b0;
        end
    end
`else
    assign long_reset_req = 1'b0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_conditioner
// Scoreboard bench: each stimulus pushes the output events it must cause
// (pulses and held edges, with their cycle numbers); a negedge monitor pops
// and compares them as the DUT produces them. Cycle numbers count posedges
// since the last reset release.
// ---------------------------------------------------------------------------
module tb_key_conditioner;

    localparam int DEB = 4;
    localparam int LP  = 16;
    localparam int LAT = DEB + 2;

    typedef enum int {
        EV_PAUSE,
        EV_START,
        EV_LONG,
        EV_PH_RISE,
        EV_PH_FALL,
        EV_SH_RISE,
        EV_SH_FALL
    } ev_kind_e;

    typedef struct {
        ev_kind_e kind;
        int       cycle;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic key_start_n = 1'b1;
    logic key_pause_n = 1'b1;
    logic start, pause, start_held, pause_held, long_reset_req;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];
    logic prev_sh = 1'b0;
    logic prev_ph = 1'b0;

    key_conditioner #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONGPRESS_CYCLES (LP)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .key_start_n    (key_start_n),
        .key_pause_n    (key_pause_n),
        .start          (start),
        .pause          (pause),
        .start_held     (start_held),
        .pause_held     (pause_held),
        .long_reset_req (long_reset_req)
    );

    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Sorted insert so same-cycle events sit in the monitor's handling order.
    task automatic expect_ev(input ev_kind_e kind, input int cycle);
        ev_t e;
        int  i;
        e.kind  = kind;
        e.cycle = cycle;
        i = 0;
        while (i < exp_q.size() &&
               (exp_q[i].cycle < cycle ||
                (exp_q[i].cycle == cycle && int'(exp_q[i].kind) <= int'(kind))))
            i++;
        exp_q.insert(i, e);
    endtask

    task automatic observe(input ev_kind_e kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            check({"unexpected ", kind.name()}, cyc, -1);
        end else begin
            e = exp_q.pop_front();
            check("event kind", int'(kind), int'(e.kind));
            check({kind.name(), " cycle"}, cyc, e.cycle);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            prev_sh = 1'b0;
            prev_ph = 1'b0;
        end else begin
            if (!start || !pause)
                check("start/pause exclusive", int'(start | pause), 1);
            if (!pause)                  observe(EV_PAUSE);
            if (!start)                  observe(EV_START);
            if (long_reset_req)          observe(EV_LONG);
            if (pause_held && !prev_ph)  observe(EV_PH_RISE);
            if (!pause_held && prev_ph)  observe(EV_PH_FALL);
            if (start_held && !prev_sh)  observe(EV_SH_RISE);
            if (!start_held && prev_sh)  observe(EV_SH_FALL);
            prev_sh = start_held;
            prev_ph = pause_held;
        end
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " start"},          int'(start), 1);
        check({tag, " pause"},          int'(pause), 1);
        check({tag, " start_held"},     int'(start_held), 0);
        check({tag, " pause_held"},     int'(pause_held), 0);
        check({tag, " long_reset_req"}, int'(long_reset_req), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_reset_vals("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic phase_done(input string tag);
        check({tag, " pending events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset then idle: no events at all.
        do_reset();
        goto(30);
        check_reset_vals("idle");
        phase_done("idle");

        // Clean pause press, 20 cycles long, from edge 10.
        do_reset();
        expect_ev(EV_PAUSE,   10 + LAT);
        expect_ev(EV_PH_RISE, 10 + LAT);
        expect_ev(EV_PH_FALL, 30 + LAT);
        goto(9);  key_pause_n = 1'b0;
        goto(29); key_pause_n = 1'b1;
        goto(45);
        phase_done("pause press");

        // Short start glitches are rejected.
        do_reset();
        goto(9);
        for (int i = 0; i < 5; i++) begin
            key_start_n = 1'b0;
            repeat (3) @(negedge clock);
            key_start_n = 1'b1;
            repeat (3) @(negedge clock);
        end
        goto(55);
        check("glitch start_held", int'(start_held), 0);
        phase_done("glitch");

        // Both keys at edge 10 for 40 cycles: pause first, start deferred.
        do_reset();
        expect_ev(EV_PAUSE,   10 + LAT);
        expect_ev(EV_START,   11 + LAT);
        expect_ev(EV_PH_RISE, 10 + LAT);
        expect_ev(EV_SH_RISE, 10 + LAT);
        expect_ev(EV_PH_FALL, 50 + LAT);
        expect_ev(EV_SH_FALL, 50 + LAT);
`ifdef KEY_LONGPRESS_EN
        expect_ev(EV_LONG, 10 + LAT + LP);
`endif
        goto(9);  key_start_n = 1'b0; key_pause_n = 1'b0;
        goto(49); key_start_n = 1'b1; key_pause_n = 1'b1;
        goto(70);
        phase_done("simultaneous");

        // Release bounce: high 2, low 1, then high; one pulse, one fall.
        do_reset();
        expect_ev(EV_START,   10 + LAT);
        expect_ev(EV_SH_RISE, 10 + LAT);
        expect_ev(EV_SH_FALL, 23 + LAT);
        goto(9);  key_start_n = 1'b0;
        goto(19); key_start_n = 1'b1;
        goto(21); key_start_n = 1'b0;
        goto(22); key_start_n = 1'b1;
        goto(45);
        phase_done("release bounce");

        // Reset during the pause pulse with the key still held: outputs clear
        // at once, then the key is re-qualified and pulses again.
        do_reset();
        expect_ev(EV_PAUSE,   5 + LAT);
        expect_ev(EV_PH_RISE, 5 + LAT);
        goto(4); key_pause_n = 1'b0;
        goto(5 + LAT);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("mid-pulse reset");
        phase_done("pre-reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        expect_ev(EV_PAUSE,   1 + LAT);
        expect_ev(EV_PH_RISE, 1 + LAT);
        expect_ev(EV_PH_FALL, 20 + LAT);
        goto(19); key_pause_n = 1'b1;
        goto(35);
        phase_done("re-qualify");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
